ram_1w_nrd: RTL

Parametrised block-RAM wrapper with one write port and NUM_RD independent read ports, all on one clock. It generalises the 1-write/2-read tile buffer used by the multi-MAC matrix-multiply array, and adds the following:
- byte-lane write enables
- per-port read enables with valid flags
- a selectable read-during-write policy
- an optional output pipeline register

It sits between the tile loader (write side) and the parallel MAC lanes (read side).

---
 rtl/ram_1w_nrd.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_1w_nrd.sv
// ---------------------------------------------------------------------------
// ram_1w_nrd
//   Block-RAM wrapper with one byte-lane-masked write port and NUM_RD fully
//   independent read ports on a single clock. It sits between the tile loader
//   (write side) and the parallel MAC lanes (read side).
//
//   Each read port has its own request strobe and a one-cycle valid pulse for
//   every accepted request. Read latency is 1 (RAM output register only) or
//   2 (one extra output register). A same-address read/write on one edge
//   returns either the old word (RDW_MODE=0) or the old word with the
//   written lanes merged in (RDW_MODE=1).
//
// Ports
//   clk         in   1                  clock, rising edge
//   rst         in   1                  synchronous active-high reset
//   we          in   1                  write strobe
//   wr_addr     in   AW                 write address
//   wr_be       in   NB                 byte-lane write enables
//   din         in   DATA_WIDTH         write data
//   rd_en       in   NUM_RD             per-port read request
//   rd_addr     in   NUM_RD*AW          packed read addresses, port p at [p*AW +: AW]
//   dout        out  NUM_RD*DATA_WIDTH  packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid  out  NUM_RD             one pulse per accepted read
// ---------------------------------------------------------------------------
module ram_1w_nrd #(
    parameter int DATA_WIDTH   = 1024,
    parameter int BYTE_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int NUM_RD       = 2,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    localparam int NB          = DATA_WIDTH / BYTE_WIDTH,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [AW-1:0]                wr_addr,
    input  logic [NB-1:0]                wr_be,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            dout_valid
);

    // Elaboration-time parameter checks.
    generate
        if ((NB < 1) || (DATA_WIDTH % BYTE_WIDTH != 0)) begin : g_bad_width
            $error("ram_1w_nrd: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
        end
        if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
            $error("ram_1w_nrd: READ_LATENCY must be 1 or 2");
        end
        if ((NUM_RD < 1) || (NUM_RD > 8)) begin : g_bad_ports
            $error("ram_1w_nrd: NUM_RD must be in 1..8");
        end
    endgenerate

    // Storage: never reset, contents survive rst.
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: only enabled lanes are updated; writes during rst are dropped.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= din[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [AW-1:0]         addr;
            logic [DATA_WIDTH-1:0] ram_q_reg;   // RAM output register
            logic                  v1_reg;      // valid for ram_q_reg stage
            logic [DATA_WIDTH-1:0] s1_data;     // stage-1 word after collision handling

            assign addr = rd_addr[gi*AW +: AW];

            // Read-first RAM access: the non-blocking write lands after this
            // read samples, so a colliding read sees the old word here.
            // The data register only loads on a request so dout holds on idle
            // cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ram_q_reg <= '0;
                    v1_reg    <= 1'b0;
                end else begin
                    v1_reg <= rd_en[gi];
                    if (rd_en[gi]) begin
                        ram_q_reg <= mem[addr];
                    end
                end
            end

            if (RDW_MODE == 1) begin : g_write_first
                // Registered bypass: on a collision, remember which bits were
                // written and with what, then overlay them on the old word.
                // A zero mask means "no collision" and passes the RAM word.
                logic [DATA_WIDTH-1:0] byp_mask_next;
                logic [DATA_WIDTH-1:0] byp_mask_reg;
                logic [DATA_WIDTH-1:0] byp_data_reg;

                always_comb begin
                    byp_mask_next = '0;
                    if (we && (addr == wr_addr)) begin
                        for (int b = 0; b < NB; b++) begin
                            byp_mask_next[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be[b]}};
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        byp_mask_reg <= '0;
                    end else if (rd_en[gi]) begin
                        byp_mask_reg <= byp_mask_next;
                        byp_data_reg <= din;
                    end
                end

                assign s1_data = (byp_data_reg & byp_mask_reg) | (ram_q_reg & ~byp_mask_reg);
            end else begin : g_read_first
                assign s1_data = ram_q_reg;
            end

            if (READ_LATENCY == 2) begin : g_lat2
                logic [DATA_WIDTH-1:0] out_reg;
                logic                  v2_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        out_reg <= '0;
                        v2_reg  <= 1'b0;
                    end else begin
                        v2_reg <= v1_reg;
                        if (v1_reg) begin
                            out_reg <= s1_data;
                        end
                    end
                end

                assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = out_reg;
                assign dout_valid[gi]                    = v2_reg;
            end else begin : g_lat1
                assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = s1_data;
                assign dout_valid[gi]                    = v1_reg;
            end
        end
    endgenerate

endmodule
